potato_timer_ctrl: RTL
======================

Name: potato_timer_ctrl

Overview:
Run-time sequencer for the potato timer: once configuration is done, it actually counts.
- Accepts a BCD mm:ss preset and a start command (countdown or count-up).
- Generates a 1 Hz tick from the system clock and steps the mm:ss digits.
- Supports pause/resume and abort.
- Issues one-cycle finish/timeout pulses that return the configuration FSM to CONFIGURE.
- Sits between the configuration/display block and the top-level I/O.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick; must be ≥2; simulation uses 4.
UP_LIMIT_M2, 5, count-up limit, minute tens digit.
UP_LIMIT_M1, 9, count-up limit, minute units digit; limit seconds are fixed at 59 (default limit 59:59).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start_down  in  1  one-cycle pulse: load preset, begin countdown.
start_up  in  1  one-cycle pulse: clear digits, begin count-up.
pause  in  1  one-cycle pulse: toggle pause while running.
abort  in  1  one-cycle pulse: stop immediately, return to IDLE.
preset_m2, preset_m1, preset_s2, preset_s1  in  4 each  BCD preset (m2 0-5, m1 0-9, s2 0-5, s1 0-9).
cur_m2, cur_m1, cur_s2, cur_s1  out  4 each  current BCD value, registered.
run_state  out  2  0 IDLE, 1 DOWN, 2 UP.
paused  out  1  high while a run is paused.
tick  out  1  one-cycle pulse on each 1 s tick; only asserted while running and not paused.
finish  out  1  one-cycle pulse when a countdown reaches 00:00.
timeout  out  1  one-cycle pulse when a count-up reaches the limit.

Behaviour:
- Reset (async): run_state=IDLE, all cur_* digits=0, paused=0, tick=finish=timeout=0, prescaler=0.
- All outputs are registered.
- Priority in any cycle: abort > start_down > start_up > pause.
- Start commands are ignored unless run_state=IDLE. pause is ignored in IDLE.
- start_down in IDLE:
  - cur_* <= preset, run_state<=DOWN, prescaler<=0.
  - If preset is 00:00: stay IDLE; finish=1 on the following cycle.
- start_up in IDLE: cur_* <= 0, run_state<=UP, prescaler<=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while running and not paused; frozen while paused.
  - Internal tick when the count equals TICK_DIV-1, after which it wraps to 0.
  - First tick arrives exactly TICK_DIV cycles after the start edge.
- DOWN, on tick: BCD decrement with borrow chain s1(0->9) -> s2(0->5) -> m1(0->9) -> m2.
  - On the tick where the value becomes 00:00: run_state<=IDLE, finish=1 on the next cycle for one cycle.
  - Digits hold 00:00.
- UP, on tick: BCD increment with carry chain s1(9->0) -> s2(5->0) -> m1(9->0) -> m2.
  - On the tick where the value reaches UP_LIMIT_M2 UP_LIMIT_M1:59: run_state<=IDLE, timeout=1 for one cycle.
  - Digits hold the limit; they never wrap past 59:59.
- pause toggles paused.
  - If pause coincides with a tick, the tick is applied first, then the block pauses.
  - Resume continues from the frozen prescaler value, so no time is lost or gained.
- abort in DOWN or UP: run_state<=IDLE, paused<=0, prescaler<=0, digits hold, no finish/timeout pulse.
  - If abort coincides with the terminal tick, abort wins: no pulse.
- Leaving a run (abort or end) clears paused.
- rst asserted mid-run forces the reset values immediately, with no pulses.
- Out-of-range BCD presets are not checked; behaviour with them is undefined and must not occur.

Decomposition:
- Shared package potato_pkg:
  - Run-state encodings RUN_IDLE=0, RUN_DOWN=1, RUN_UP=2.
  - BCD digit maxima (units 9, tens 5).
  - Function bcd_is_zero.
- One sub-module, potato_tick_gen: TICK_DIV prescaler with clear and enable inputs and a tick output.
- The BCD inc/dec chain and FSM stay in potato_timer_ctrl.

Test Plan (all with TICK_DIV=4):
1. Preset 00:03, start_down -> tick every 4 cycles; digits 00:02, 00:01, 00:00; finish pulses once ~12 cycles after start; run_state=IDLE.
2. Preset 01:00, start_down -> first tick yields 00:59 (borrow across m1/s2/s1); preset 10:00 -> first tick yields 09:59.
3. start_up with limits 0,0 (limit 00:59) -> counts 00:00..00:59; timeout pulses once on reaching 00:59; digits hold 00:59.
4. Preset 00:05, start_down, pause after 2 ticks, hold 20 cycles -> digits frozen at 00:03, no tick. Pause again -> resumes; finish arrives exactly 20 cycles later than in the unpaused case.
5. Abort on the same cycle as the terminal tick of 00:01 -> IDLE, no finish. start_up during DOWN -> ignored. Preset 00:00 start_down -> immediate finish, stays IDLE.
6. Assert rst mid count-up at 00:07 -> all digits 0, IDLE, paused=0 asynchronously; no timeout pulse.

Source files
------------

// File: rtl/potato_pkg.sv
// Shared definitions for the potato timer run-time sequencer:
// run-state encodings, BCD digit limits and an mm:ss time record.
package potato_pkg;

  typedef enum logic [1:0] {
    RUN_IDLE = 2'd0,
    RUN_DOWN = 2'd1,
    RUN_UP   = 2'd2
  } run_state_e;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  typedef struct packed {
    logic [3:0] m2;
    logic [3:0] m1;
    logic [3:0] s2;
    logic [3:0] s1;
  } bcd_time_t;

  function automatic logic bcd_is_zero(input bcd_time_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/potato_tick_gen.sv
// Prescaler producing one tick every TICK_DIV enabled cycles; the count
// freezes while disabled so a pause neither loses nor gains time.
module potato_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/potato_timer_ctrl.sv
// Run-time sequencer: loads a BCD mm:ss preset, counts down or up on 1 s
// ticks, handles pause/abort and pulses finish/timeout at the end of a run.
module potato_timer_ctrl
  import potato_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned UP_LIMIT_M2 = 5,
  parameter int unsigned UP_LIMIT_M1 = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_down,
  input  logic       start_up,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] preset_m2,
  input  logic [3:0] preset_m1,
  input  logic [3:0] preset_s2,
  input  logic [3:0] preset_s1,
  output logic [3:0] cur_m2,
  output logic [3:0] cur_m1,
  output logic [3:0] cur_s2,
  output logic [3:0] cur_s1,
  output logic [1:0] run_state,
  output logic       paused,
  output logic       tick,
  output logic       finish,
  output logic       timeout
);

  localparam bcd_time_t LIMIT = {4'(UP_LIMIT_M2), 4'(UP_LIMIT_M1), BCD_TENS_MAX, BCD_UNITS_MAX};

  run_state_e state_q;
  bcd_time_t  cur_q;
  bcd_time_t  cur_dec;
  bcd_time_t  cur_inc;
  bcd_time_t  preset;
  logic       paused_q;
  logic       tick_q;
  logic       finish_q;
  logic       timeout_q;
  logic       is_idle;
  logic       go_down;
  logic       go_up;
  logic       tick_int;

  assign preset  = {preset_m2, preset_m1, preset_s2, preset_s1};
  assign is_idle = (state_q == RUN_IDLE);
  assign go_down = !abort && is_idle && start_down;
  assign go_up   = !abort && is_idle && !start_down && start_up;

  potato_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (abort || go_down || go_up),
    .enable_i (!is_idle && !paused_q),
    .tick_o   (tick_int)
  );

  // Borrow/carry chains; DOWN never sees 00:00 and UP stops at LIMIT.
  always_comb begin
    cur_dec = cur_q;
    if (cur_q.s1 != 4'd0) begin
      cur_dec.s1 = cur_q.s1 - 4'd1;
    end else begin
      cur_dec.s1 = BCD_UNITS_MAX;
      if (cur_q.s2 != 4'd0) begin
        cur_dec.s2 = cur_q.s2 - 4'd1;
      end else begin
        cur_dec.s2 = BCD_TENS_MAX;
        if (cur_q.m1 != 4'd0) begin
          cur_dec.m1 = cur_q.m1 - 4'd1;
        end else begin
          cur_dec.m1 = BCD_UNITS_MAX;
          cur_dec.m2 = cur_q.m2 - 4'd1;
        end
      end
    end

    cur_inc = cur_q;
    if (cur_q.s1 != BCD_UNITS_MAX) begin
      cur_inc.s1 = cur_q.s1 + 4'd1;
    end else begin
      cur_inc.s1 = 4'd0;
      if (cur_q.s2 != BCD_TENS_MAX) begin
        cur_inc.s2 = cur_q.s2 + 4'd1;
      end else begin
        cur_inc.s2 = 4'd0;
        if (cur_q.m1 != BCD_UNITS_MAX) begin
          cur_inc.m1 = cur_q.m1 + 4'd1;
        end else begin
          cur_inc.m1 = 4'd0;
          cur_inc.m2 = cur_q.m2 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN_IDLE;
      cur_q     <= '0;
      paused_q  <= 1'b0;
      tick_q    <= 1'b0;
      finish_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      finish_q  <= 1'b0;
      timeout_q <= 1'b0;
      if (abort) begin
        state_q  <= RUN_IDLE;
        paused_q <= 1'b0;
      end else if (is_idle) begin
        if (go_down) begin
          cur_q <= preset;
          if (bcd_is_zero(preset)) finish_q <= 1'b1;
          else                     state_q  <= RUN_DOWN;
        end else if (go_up) begin
          cur_q   <= '0;
          state_q <= RUN_UP;
        end
      end else begin
        if (pause) paused_q <= !paused_q;
        // The tick lands first; a terminal tick then overrides the pause toggle.
        if (tick_int) begin
          tick_q <= 1'b1;
          if (state_q == RUN_DOWN) begin
            cur_q <= cur_dec;
            if (bcd_is_zero(cur_dec)) begin
              state_q  <= RUN_IDLE;
              paused_q <= 1'b0;
              finish_q <= 1'b1;
            end
          end else begin
            cur_q <= cur_inc;
            if (cur_inc == LIMIT) begin
              state_q   <= RUN_IDLE;
              paused_q  <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign cur_m2    = cur_q.m2;
  assign cur_m1    = cur_q.m1;
  assign cur_s2    = cur_q.s2;
  assign cur_s1    = cur_q.s1;
  assign run_state = state_q;
  assign paused    = paused_q;
  assign tick      = tick_q;
  assign finish    = finish_q;
  assign timeout   = timeout_q;

endmodule
